// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the main-memory request arbiter.
// Holds the FSM encoding, requester IDs and the line-offset helper.
package mem_req_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // Number of byte-offset bits covered by one full line burst.
    function automatic int line_off_bits(input int burst_len, input int data_w);
        return $clog2(burst_len * data_w / 8);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave view; caches plus memory controller use the master view.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic              ic_done;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wready;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic              dc_done;

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
               mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        output ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
               mem_cmd_ready, mem_wready, mem_rdata, mem_rvalid,
        input  ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
               mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid, busy
    );

endinterface

// File: rtl/mem_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is granted.
module rr_arb2
    import mem_req_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant from the current requests and the previous winner.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == REQ_D) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the main-memory port between icache fills and dcache fills/write-backs.
// One line burst per grant; the winner owns the port until its done pulse.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_req_arbiter_if.slave     bus
);

    localparam int                CNT_W      = $clog2(BURST_LEN);
    localparam int                OFF_W      = line_off_bits(BURST_LEN, DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    state_t            state_q;
    logic              winner_q;
    logic              we_q;
    logic              last_gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              cmd_valid_q;
    logic              busy_q;
    logic              ic_done_q;
    logic              dc_done_q;

    logic [1:0]        gnt_s;
    logic              rd_beat_s;
    logic              wr_phase_s;

    rr_arb2 u_rr_arb2 (
        .req_i  ({bus.dc_req, bus.ic_req}),
        .last_i (last_gnt_q),
        .gnt_o  (gnt_s)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    // Arbitration, command phase, beat counting and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            winner_q    <= REQ_I;
            we_q        <= 1'b0;
            last_gnt_q  <= REQ_I;
            addr_q      <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_s != 2'b00) begin
                        winner_q    <= gnt_s[REQ_D];
                        we_q        <= gnt_s[REQ_D] & bus.dc_we;
                        addr_q      <= gnt_s[REQ_D] ? bus.dc_addr : bus.ic_addr;
                        last_gnt_q  <= gnt_s[REQ_D];
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= we_q ? S_WDATA : S_RDATA;
                    end
                end
                S_RDATA, S_WDATA: begin
                    // A beat completes on rvalid when reading, on wready when writing.
                    if ((state_q == S_RDATA) ? bus.mem_rvalid : bus.mem_wready) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q     <= {CNT_W{1'b0}};
                            ic_done_q <= (winner_q == REQ_I);
                            dc_done_q <= (winner_q == REQ_D);
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    ic_done_q <= 1'b0;
                    dc_done_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    ic_done_q   <= 1'b0;
                    dc_done_q   <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_beat_s  = (state_q == S_RDATA) && bus.mem_rvalid;
    assign wr_phase_s = (state_q == S_WDATA);

    assign bus.ic_rvalid     = rd_beat_s && (winner_q == REQ_I);
    assign bus.ic_rdata      = bus.ic_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.dc_rvalid     = rd_beat_s && (winner_q == REQ_D);
    assign bus.dc_rdata      = bus.dc_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.ic_done       = ic_done_q;
    assign bus.dc_done       = dc_done_q;

    assign bus.mem_cmd_valid = cmd_valid_q;
    assign bus.mem_cmd_we    = we_q;
    assign bus.mem_cmd_addr  = addr_q & ALIGN_MASK;
    assign bus.mem_wvalid    = wr_phase_s;
    assign bus.mem_wdata     = wr_phase_s ? bus.dc_wdata : {DATA_W{1'b0}};
    assign bus.dc_wready     = wr_phase_s && bus.mem_wready;

    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench for mem_req_arbiter: the stimulus pushes expectations,
// a negedge monitor pops and compares whenever the DUT presents a command, beat or done.
module tb_mem_req_arbiter;

    logic clk;
    logic rst;

    mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] cmd_q[$];
    logic [31:0] ic_q[$];
    logic [31:0] dc_q[$];
    logic [31:0] wd_q[$];
    logic [1:0]  done_q[$];
    logic        prev_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexp(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected event value %h, expected none, at %0t", name, act, $time);
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                if (cmd_q.size() == 0) unexp("cmd", {31'b0, bus.mem_cmd_we, bus.mem_cmd_addr});
                else chk("cmd", {31'b0, bus.mem_cmd_we, bus.mem_cmd_addr}, cmd_q.pop_front());
            end
            if (bus.ic_rvalid) begin
                if (ic_q.size() == 0) unexp("ic_beat", {32'b0, bus.ic_rdata});
                else chk("ic_beat", {32'b0, bus.ic_rdata}, {32'b0, ic_q.pop_front()});
            end
            if (bus.dc_rvalid) begin
                if (dc_q.size() == 0) unexp("dc_beat", {32'b0, bus.dc_rdata});
                else chk("dc_beat", {32'b0, bus.dc_rdata}, {32'b0, dc_q.pop_front()});
            end
            if (bus.mem_wvalid) begin
                chk("dc_wready", {63'b0, bus.dc_wready}, {63'b0, bus.mem_wready});
                if (bus.mem_wready) begin
                    if (wd_q.size() == 0) unexp("wbeat", {32'b0, bus.mem_wdata});
                    else chk("wbeat", {32'b0, bus.mem_wdata}, {32'b0, wd_q.pop_front()});
                end
            end
            if (bus.ic_done || bus.dc_done) begin
                if (done_q.size() == 0) unexp("done", {62'b0, bus.dc_done, bus.ic_done});
                else chk("done", {62'b0, bus.dc_done, bus.ic_done}, {62'b0, done_q.pop_front()});
                if (prev_done) unexp("done_width", {62'b0, bus.dc_done, bus.ic_done});
            end
            prev_done <= bus.ic_done | bus.dc_done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ic"}, {bus.ic_rdata, 29'b0, bus.ic_rvalid, bus.ic_done, bus.busy}, 64'd0);
        chk({name, "_dc"}, {bus.dc_rdata, 29'b0, bus.dc_rvalid, bus.dc_done, bus.dc_wready}, 64'd0);
        chk({name, "_cmd"}, {bus.mem_cmd_addr, 30'b0, bus.mem_cmd_valid, bus.mem_cmd_we}, 64'd0);
        chk({name, "_wr"}, {bus.mem_wdata, 31'b0, bus.mem_wvalid}, 64'd0);
    endtask

    // Accept the next command; the handshake itself is checked by the monitor.
    task automatic wait_cmd();
        bit seen;
        seen = 1'b0;
        bus.mem_cmd_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.mem_cmd_valid) seen = 1'b1;
            cyc();
        end
        bus.mem_cmd_ready = 1'b0;
        if (!seen) unexp("cmd_timeout", 64'd0);
    endtask

    task automatic rd_beats(input logic [31:0] base, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = base + 32'(i);
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] addr);
        cmd_q.push_back({31'b0, we, addr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        bit acc;
        logic who;
        rst = 1'b1;
        bus.ic_req = 1'b0; bus.ic_addr = 32'h0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = 32'h0; bus.dc_wdata = 32'h0;
        bus.mem_cmd_ready = 1'b0; bus.mem_wready = 1'b0;
        bus.mem_rdata = 32'h0; bus.mem_rvalid = 1'b0;
        do_reset();
        check_all_zero("reset");

        // 1: icache line read, unaligned address
        push_cmd(1'b0, 32'h1000_0010);
        for (int i = 0; i < 4; i++) ic_q.push_back(32'hA0 + 32'(i));
        done_q.push_back(2'b01);
        bus.ic_req = 1'b1; bus.ic_addr = 32'h1000_0014;
        cyc();
        wait_cmd();
        rd_beats(32'hA0, 0, 4);
        chk("t1_ic_done", {63'b0, bus.ic_done}, 64'd1);
        bus.ic_req = 1'b0;
        cyc();

        // 2: dcache write-back with mem_wready toggling
        push_cmd(1'b1, 32'h1000_0100);
        for (int i = 0; i < 4; i++) wd_q.push_back(32'hD0 + 32'(i));
        done_q.push_back(2'b10);
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h1000_0100;
        cyc();
        wait_cmd();
        w = 0;
        for (int k = 0; k < 20 && w < 4; k++) begin
            bus.mem_wready = (k % 2 == 0);
            bus.dc_wdata   = 32'hD0 + 32'(w);
            acc = bus.mem_wvalid && bus.mem_wready;
            cyc();
            if (acc) w++;
        end
        bus.mem_wready = 1'b0;
        chk("t2_beats", 64'(w), 64'd4);
        chk("t2_dc_done", {63'b0, bus.dc_done}, 64'd1);
        bus.dc_req = 1'b0; bus.dc_we = 1'b0;
        cyc();

        // 3: simultaneous requests after reset alternate D, I, D, I
        do_reset();
        for (int k = 0; k < 4; k++) begin
            who = (k % 2 == 0);
            push_cmd(1'b0, who ? 32'h3000_0040 : 32'h2000_0000);
            for (int i = 0; i < 4; i++) begin
                if (who) dc_q.push_back(32'h100 + 32'(16 * k + i));
                else     ic_q.push_back(32'h100 + 32'(16 * k + i));
            end
            done_q.push_back(who ? 2'b10 : 2'b01);
        end
        bus.ic_addr = 32'h2000_0000; bus.dc_addr = 32'h3000_0044; bus.dc_we = 1'b0;
        bus.ic_req = 1'b1; bus.dc_req = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            who = (k % 2 == 0);
            wait_cmd();
            rd_beats(32'h100 + 32'(16 * k), 0, 4);
            if (who) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
            cyc();
            if (k < 2) begin
                if (who) bus.dc_req = 1'b1; else bus.ic_req = 1'b1;
            end
        end
        cyc();

        // 4: command backpressure holds fields and blocks data steering
        push_cmd(1'b0, 32'h4000_0000);
        for (int i = 0; i < 4; i++) ic_q.push_back(32'h40 + 32'(i));
        done_q.push_back(2'b01);
        bus.ic_req = 1'b1; bus.ic_addr = 32'h4000_0008;
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hEE;
            #1;
            chk("t4_hold", {bus.mem_cmd_addr, 28'b0, bus.mem_cmd_valid, bus.mem_cmd_we, bus.busy, bus.mem_wvalid},
                {32'h4000_0000, 28'b0, 1'b1, 1'b0, 1'b1, 1'b0});
            chk("t4_nosteer", {62'b0, bus.ic_rvalid, bus.dc_rvalid}, 64'd0);
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        wait_cmd();
        rd_beats(32'h40, 0, 4);
        chk("t4_ic_done", {63'b0, bus.ic_done}, 64'd1);
        bus.ic_req = 1'b0;
        cyc();

        // 5: reset during the read burst aborts it; a new request then completes
        push_cmd(1'b0, 32'h5000_0020);
        for (int i = 0; i < 2; i++) ic_q.push_back(32'h50 + 32'(i));
        bus.ic_req = 1'b1; bus.ic_addr = 32'h5000_0020;
        cyc();
        wait_cmd();
        rd_beats(32'h50, 0, 2);
        rst = 1'b1; bus.ic_req = 1'b0;
        cyc();
        check_all_zero("t5_rst");
        rst = 1'b0;
        push_cmd(1'b0, 32'h5000_0020);
        for (int i = 0; i < 4; i++) ic_q.push_back(32'h60 + 32'(i));
        done_q.push_back(2'b01);
        bus.ic_req = 1'b1; bus.ic_addr = 32'h5000_0028;
        cyc();
        wait_cmd();
        rd_beats(32'h60, 0, 4);
        chk("t5_ic_done", {63'b0, bus.ic_done}, 64'd1);
        bus.ic_req = 1'b0;
        cyc();

        // 6: dcache read with request dropped after beat 1, then stray rvalid in IDLE
        push_cmd(1'b0, 32'h6000_0000);
        for (int i = 0; i < 4; i++) dc_q.push_back(32'h70 + 32'(i));
        done_q.push_back(2'b10);
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h6000_0004;
        cyc();
        wait_cmd();
        rd_beats(32'h70, 0, 2);
        bus.dc_req = 1'b0;
        rd_beats(32'h70, 2, 2);
        chk("t6_dc_done", {63'b0, bus.dc_done}, 64'd1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD;
            #1;
            chk("t6_stray", {61'b0, bus.ic_rvalid, bus.dc_rvalid, bus.busy}, 64'd0);
            cyc();
        end
        bus.mem_rvalid = 1'b0;
        cyc();

        chk("cmd_q_left", 64'(cmd_q.size()), 64'd0);
        chk("ic_q_left", 64'(ic_q.size()), 64'd0);
        chk("dc_q_left", 64'(dc_q.size()), 64'd0);
        chk("wd_q_left", 64'(wd_q.size()), 64'd0);
        chk("done_q_left", 64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
